// File: rtl/dump_sequencer.sv
// One-channel dump sequencer: reads the channel's offset and gain from the EEPROM over SPI,
// then streams the circular capture RAM to the UART path, starting at the oldest sample.
module dump_sequencer #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump,
    input  logic [1:0]        dump_ch,
    input  logic [2:0]        ch1_AFEgain,
    input  logic [2:0]        ch2_AFEgain,
    input  logic [2:0]        ch3_AFEgain,
    input  logic [ADDR_W-1:0] trig_addr,
    output logic              wrt_SPI,
    output logic [2:0]        ss,
    output logic [15:0]       SPI_data,
    input  logic              SPI_done,
    input  logic [7:0]        EEP_data,
    output logic              flopOffset,
    output logic              flopGain,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [1:0]        ram_ch,
    input  logic [7:0]        RAM_rdata,
    output logic [7:0]        sample,
    output logic              send_resp,
    input  logic              resp_sent,
    output logic              busy,
    output logic              dump_done,
    output logic              dump_err
);

    // state   | meaning
    // IDLE    | waiting for a dump strobe
    // RD_OFF  | launch EEPROM read of the offset
    // WT_OFF  | wait for SPI_done, load offset register
    // RD_GAIN | launch EEPROM read of the gain
    // WT_GAIN | wait for SPI_done, load gain register
    // RAM_RD  | issue RAM read at the current pointer
    // RAM_LAT | capture RAM read data into sample
    // SEND    | strobe the UART transmitter
    // WT_UART | wait for resp_sent, advance or finish
    // DONE    | completion pulse
    typedef enum logic [3:0] {
        IDLE, RD_OFF, WT_OFF, RD_GAIN, WT_GAIN,
        RAM_RD, RAM_LAT, SEND, WT_UART, DONE
    } state_t;

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DEPTH - 1);

    state_t            state, nxt;
    logic [1:0]        ch;
    logic [2:0]        g;
    logic [2:0]        gain_sel;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_inc;
    logic [ADDR_W-1:0] first_ptr;
    logic              last_byte;
    logic              accept;
    logic              wrt_q;
    logic              err_q;
    logic [2:0]        ss_q;
    logic [15:0]       spi_data_q;
    logic [7:0]        sample_q;

    // EEPROM read data is consumed by the correction registers on the load strobes.
    logic unused_eep;
    assign unused_eep = ^EEP_data;

    always_comb begin
        gain_sel = 3'b000;
        case (dump_ch)
            2'b00:   gain_sel = ch1_AFEgain;
            2'b01:   gain_sel = ch2_AFEgain;
            2'b10:   gain_sel = ch3_AFEgain;
            default: gain_sel = 3'b000;
        endcase
    end

    assign accept    = (state == IDLE) && dump && (dump_ch != 2'b11);
    assign first_ptr = (trig_addr == LAST_ADDR) ? '0 : trig_addr + ADDR_W'(1);
    assign ptr_inc   = (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
    assign last_byte = (cnt == LAST_CNT);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = RD_OFF;
            RD_OFF:  nxt = WT_OFF;
            WT_OFF:  if (SPI_done) nxt = RD_GAIN;
            RD_GAIN: nxt = WT_GAIN;
            WT_GAIN: if (SPI_done) nxt = RAM_RD;
            RAM_RD:  nxt = RAM_LAT;
            RAM_LAT: nxt = SEND;
            SEND:    nxt = WT_UART;
            WT_UART: if (resp_sent) nxt = last_byte ? DONE : RAM_RD;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ch         <= '0;
            g          <= '0;
            cnt        <= '0;
            ptr        <= '0;
            wrt_q      <= 1'b0;
            err_q      <= 1'b0;
            ss_q       <= '0;
            spi_data_q <= '0;
            sample_q   <= '0;
        end else begin
            state <= nxt;
            wrt_q <= (state == RD_OFF) || (state == RD_GAIN);
            err_q <= (state == IDLE) && dump && (dump_ch == 2'b11);
            case (state)
                IDLE: begin
                    if (accept) begin
                        ch         <= dump_ch;
                        g          <= gain_sel;
                        ptr        <= first_ptr;
                        cnt        <= '0;
                        ss_q       <= 3'b100;
                        spi_data_q <= {2'b00, dump_ch, gain_sel, 1'b0, 8'h00};
                    end
                end
                WT_OFF: begin
                    if (SPI_done) spi_data_q <= {2'b00, ch, g, 1'b1, 8'h00};
                end
                WT_GAIN: begin
                    if (SPI_done) begin
                        ss_q       <= '0;
                        spi_data_q <= '0;
                    end
                end
                RAM_LAT: sample_q <= RAM_rdata;
                WT_UART: begin
                    if (resp_sent && !last_byte) begin
                        cnt <= cnt + CNT_W'(1);
                        ptr <= ptr_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Load strobes are gated by rst so a coincident SPI_done cannot load a register.
    assign flopOffset = (state == WT_OFF) && SPI_done && !rst;
    assign flopGain   = (state == WT_GAIN) && SPI_done && !rst;
    assign wrt_SPI    = wrt_q;
    assign dump_err   = err_q;
    assign ss         = ss_q;
    assign SPI_data   = spi_data_q;
    assign ram_re     = (state == RAM_RD);
    assign ram_addr   = ptr;
    assign ram_ch     = ch;
    assign sample     = sample_q;
    assign send_resp  = (state == SEND);
    assign dump_done  = (state == DONE);
    assign busy       = (state != IDLE) && (state != DONE);

endmodule
